// File: rtl/id_stage_pipelined.sv
// Decode stage with an integrated ID/EX register: decode, register-file read with
// writeback bypass, load-use stall detection and branch flush.
module id_stage_pipelined #(
  parameter int DATA_W    = 32,
  parameter int REG_COUNT = 32,
  parameter int BYPASS    = 1,
  localparam int REG_AW   = $clog2(REG_COUNT)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              instr_valid,
  input  logic [31:0]       instruction,
  input  logic              wb_reg_write,
  input  logic [REG_AW-1:0] wb_write_reg,
  input  logic [DATA_W-1:0] wb_write_data,
  input  logic              flush,
  output logic              stall,
  output logic              ex_valid,
  output logic              ex_reg_write,
  output logic              ex_mem_to_reg,
  output logic              ex_branch,
  output logic              ex_mem_write,
  output logic              ex_mem_read,
  output logic              ex_alu_src,
  output logic              ex_reg_dst,
  output logic [1:0]        ex_alu_op,
  output logic              ex_illegal,
  output logic [DATA_W-1:0] ex_imm,
  output logic [DATA_W-1:0] ex_rs_data,
  output logic [DATA_W-1:0] ex_rt_data,
  output logic [REG_AW-1:0] ex_rs,
  output logic [REG_AW-1:0] ex_rt,
  output logic [REG_AW-1:0] ex_rd
);

  logic [DATA_W-1:0] regs_r [REG_COUNT];
  logic [5:0]        opcode_s;
  logic [REG_AW-1:0] rs_idx_s;
  logic [REG_AW-1:0] rt_idx_s;
  logic [REG_AW-1:0] rd_idx_s;
  logic [8:0]        dec_ctrl_s;
  logic              dec_illegal_s;
  logic [DATA_W-1:0] rs_data_s;
  logic [DATA_W-1:0] rt_data_s;
  logic [8:0]        ctrl_r;
  logic              valid_r;
  logic              illegal_r;

  assign opcode_s = instruction[31:26];
  assign rs_idx_s = instruction[21 +: REG_AW];
  assign rt_idx_s = instruction[16 +: REG_AW];
  assign rd_idx_s = instruction[11 +: REG_AW];

  // Reg 0 is hard zero; a same-cycle writeback to the read index wins when bypassing.
  function automatic logic [DATA_W-1:0] read_port(
    input logic [REG_AW-1:0] idx,
    input logic [DATA_W-1:0] stored,
    input logic              wr_en,
    input logic [REG_AW-1:0] wr_idx,
    input logic [DATA_W-1:0] wr_data
  );
    logic [DATA_W-1:0] val;
    if (idx == {REG_AW{1'b0}}) begin
      val = {DATA_W{1'b0}};
    end else if ((BYPASS == 1) && wr_en && (wr_idx == idx)) begin
      val = wr_data;
    end else begin
      val = stored;
    end
    return val;
  endfunction

  // Opcode decode: {reg_write, mem_to_reg, branch, mem_write, mem_read, alu_src, reg_dst, alu_op}
  always_comb begin
    dec_ctrl_s    = 9'b0;
    dec_illegal_s = 1'b0;
    case (opcode_s)
      6'h00:   dec_ctrl_s = 9'b1000001_10;
      6'h23:   dec_ctrl_s = 9'b1100110_00;
      6'h2B:   dec_ctrl_s = 9'b0001010_00;
      6'h04:   dec_ctrl_s = 9'b0010000_01;
      6'h08:   dec_ctrl_s = 9'b1000010_00;
      default: dec_illegal_s = 1'b1;
    endcase
  end

  assign rs_data_s = read_port(rs_idx_s, regs_r[rs_idx_s], wb_reg_write, wb_write_reg, wb_write_data);
  assign rt_data_s = read_port(rt_idx_s, regs_r[rt_idx_s], wb_reg_write, wb_write_reg, wb_write_data);

  assign stall = valid_r & ctrl_r[4] & instr_valid & (ex_rt != {REG_AW{1'b0}}) &
                 ((ex_rt == rs_idx_s) | (ex_rt == rt_idx_s));

  // Register file write port; reset clears every entry.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        regs_r[i] <= {DATA_W{1'b0}};
      end
    end else if (wb_reg_write && (wb_write_reg != {REG_AW{1'b0}})) begin
      regs_r[wb_write_reg] <= wb_write_data;
    end
  end

  // ID/EX register: data fields load every cycle, controls become a bubble on flush or stall.
  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_r    <= 1'b0;
      ctrl_r     <= 9'b0;
      illegal_r  <= 1'b0;
      ex_imm     <= {DATA_W{1'b0}};
      ex_rs_data <= {DATA_W{1'b0}};
      ex_rt_data <= {DATA_W{1'b0}};
      ex_rs      <= {REG_AW{1'b0}};
      ex_rt      <= {REG_AW{1'b0}};
      ex_rd      <= {REG_AW{1'b0}};
    end else begin
      ex_imm     <= {{(DATA_W-16){instruction[15]}}, instruction[15:0]};
      ex_rs_data <= rs_data_s;
      ex_rt_data <= rt_data_s;
      ex_rs      <= rs_idx_s;
      ex_rt      <= rt_idx_s;
      ex_rd      <= rd_idx_s;
      if (flush || stall) begin
        valid_r   <= 1'b0;
        ctrl_r    <= 9'b0;
        illegal_r <= 1'b0;
      end else begin
        valid_r   <= instr_valid;
        ctrl_r    <= instr_valid ? dec_ctrl_s : 9'b0;
        illegal_r <= instr_valid & dec_illegal_s;
      end
    end
  end

  assign ex_valid      = valid_r;
  assign ex_reg_write  = ctrl_r[8];
  assign ex_mem_to_reg = ctrl_r[7];
  assign ex_branch     = ctrl_r[6];
  assign ex_mem_write  = ctrl_r[5];
  assign ex_mem_read   = ctrl_r[4];
  assign ex_alu_src    = ctrl_r[3];
  assign ex_reg_dst    = ctrl_r[2];
  assign ex_alu_op     = ctrl_r[1:0];
  assign ex_illegal    = illegal_r;

endmodule

// File: tb/tb_id_stage_pipelined.sv
// Directed vector bench for id_stage_pipelined; a second instance with BYPASS=0
// shares the stimulus to check the non-bypassed register read.
module tb_id_stage_pipelined;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_valid;
  logic [31:0] instruction;
  logic        wb_reg_write;
  logic [4:0]  wb_write_reg;
  logic [31:0] wb_write_data;
  logic        flush;

  logic        stall, ex_valid, ex_reg_write, ex_mem_to_reg, ex_branch, ex_mem_write;
  logic        ex_mem_read, ex_alu_src, ex_reg_dst, ex_illegal;
  logic [1:0]  ex_alu_op;
  logic [31:0] ex_imm, ex_rs_data, ex_rt_data;
  logic [4:0]  ex_rs, ex_rt, ex_rd;

  logic        nb_stall, nb_valid, nb_reg_write, nb_mem_to_reg, nb_branch, nb_mem_write;
  logic        nb_mem_read, nb_alu_src, nb_reg_dst, nb_illegal;
  logic [1:0]  nb_alu_op;
  logic [31:0] nb_imm, nb_rs_data, nb_rt_data;
  logic [4:0]  nb_rs, nb_rt, nb_rd;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  id_stage_pipelined #(.DATA_W(32), .REG_COUNT(32), .BYPASS(1)) dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instruction(instruction),
    .wb_reg_write(wb_reg_write), .wb_write_reg(wb_write_reg), .wb_write_data(wb_write_data),
    .flush(flush), .stall(stall), .ex_valid(ex_valid), .ex_reg_write(ex_reg_write),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_branch(ex_branch), .ex_mem_write(ex_mem_write),
    .ex_mem_read(ex_mem_read), .ex_alu_src(ex_alu_src), .ex_reg_dst(ex_reg_dst),
    .ex_alu_op(ex_alu_op), .ex_illegal(ex_illegal), .ex_imm(ex_imm),
    .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd)
  );

  id_stage_pipelined #(.DATA_W(32), .REG_COUNT(32), .BYPASS(0)) dut_nb (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instruction(instruction),
    .wb_reg_write(wb_reg_write), .wb_write_reg(wb_write_reg), .wb_write_data(wb_write_data),
    .flush(flush), .stall(nb_stall), .ex_valid(nb_valid), .ex_reg_write(nb_reg_write),
    .ex_mem_to_reg(nb_mem_to_reg), .ex_branch(nb_branch), .ex_mem_write(nb_mem_write),
    .ex_mem_read(nb_mem_read), .ex_alu_src(nb_alu_src), .ex_reg_dst(nb_reg_dst),
    .ex_alu_op(nb_alu_op), .ex_illegal(nb_illegal), .ex_imm(nb_imm),
    .ex_rs_data(nb_rs_data), .ex_rt_data(nb_rt_data), .ex_rs(nb_rs), .ex_rt(nb_rt), .ex_rd(nb_rd)
  );

  // {reg_write, mem_to_reg, branch, mem_write, mem_read, alu_src, reg_dst, alu_op, illegal}
  localparam logic [9:0] C_NONE = 10'b0000000_00_0;
  localparam logic [9:0] C_R    = 10'b1000001_10_0;
  localparam logic [9:0] C_LW   = 10'b1100110_00_0;
  localparam logic [9:0] C_SW   = 10'b0001010_00_0;
  localparam logic [9:0] C_BEQ  = 10'b0010000_01_0;
  localparam logic [9:0] C_ADDI = 10'b1000010_00_0;
  localparam logic [9:0] C_ILL  = 10'b0000000_00_1;

  typedef struct {
    logic        iv;
    logic [31:0] ins;
    logic        wbe;
    logic [4:0]  wbr;
    logic [31:0] wbd;
    logic        fl;
    logic        stall;
    logic        v;
    logic [9:0]  ctrl;
    logic [31:0] imm;
    logic [31:0] rs;
    logic [31:0] rs_nb;
    logic [31:0] rt;
    logic [4:0]  rti;
  } vec_t;

  vec_t vq[$];

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd);
    return {6'h00, rs, rt, rd, 5'h00, 6'h20};
  endfunction

  function automatic logic [9:0] act_ctrl();
    return {ex_reg_write, ex_mem_to_reg, ex_branch, ex_mem_write, ex_mem_read,
            ex_alu_src, ex_reg_dst, ex_alu_op, ex_illegal};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end else begin
      passed++;
    end
  endtask

  task automatic drive(input logic iv, input logic [31:0] ins, input logic wbe,
                       input logic [4:0] wbr, input logic [31:0] wbd, input logic fl);
    instr_valid   = iv;
    instruction   = ins;
    wb_reg_write  = wbe;
    wb_write_reg  = wbr;
    wb_write_data = wbd;
    flush         = fl;
  endtask

  initial begin
    //            iv    ins                                wbe   wbr    wbd           fl    stall v     ctrl    imm            rs            rs_nb         rt            rti
    vq.push_back('{1'b1, itype(6'h08, 5'd0, 5'd1, 16'h0005), 1'b0, 5'd0, 32'h0,       1'b0, 1'b0, 1'b1, C_ADDI, 32'h00000005, 32'h0,        32'h0,        32'h0,        5'd1});
    vq.push_back('{1'b1, itype(6'h08, 5'd3, 5'd7, 16'h8000), 1'b1, 5'd3, 32'hDEAD,    1'b0, 1'b0, 1'b1, C_ADDI, 32'hFFFF8000, 32'hDEAD,     32'h0,        32'h0,        5'd7});
    vq.push_back('{1'b1, rtype(5'd3, 5'd0, 5'd8),            1'b0, 5'd0, 32'h0,       1'b0, 1'b0, 1'b1, C_R,    32'h00004020, 32'hDEAD,     32'hDEAD,     32'h0,        5'd0});
    vq.push_back('{1'b1, rtype(5'd0, 5'd3, 5'd9),            1'b1, 5'd0, 32'h1234,    1'b0, 1'b0, 1'b1, C_R,    32'h00004820, 32'h0,        32'h0,        32'hDEAD,     5'd3});
    vq.push_back('{1'b1, rtype(5'd0, 5'd0, 5'd10),           1'b0, 5'd0, 32'h0,       1'b0, 1'b0, 1'b1, C_R,    32'h00005020, 32'h0,        32'h0,        32'h0,        5'd0});
    vq.push_back('{1'b0, 32'h0,                              1'b1, 5'd2, 32'h22,      1'b0, 1'b0, 1'b0, C_NONE, 32'h0,        32'h0,        32'h0,        32'h0,        5'd0});
    vq.push_back('{1'b1, itype(6'h23, 5'd1, 5'd2, 16'h0000), 1'b1, 5'd5, 32'h55,      1'b0, 1'b0, 1'b1, C_LW,   32'h0,        32'h0,        32'h0,        32'h22,       5'd2});
    vq.push_back('{1'b1, rtype(5'd2, 5'd5, 5'd4),            1'b0, 5'd0, 32'h0,       1'b0, 1'b1, 1'b0, C_NONE, 32'h00002020, 32'h22,       32'h22,       32'h55,       5'd5});
    vq.push_back('{1'b1, rtype(5'd2, 5'd5, 5'd4),            1'b0, 5'd0, 32'h0,       1'b0, 1'b0, 1'b1, C_R,    32'h00002020, 32'h22,       32'h22,       32'h55,       5'd5});
    vq.push_back('{1'b1, itype(6'h2B, 5'd2, 5'd6, 16'h0004), 1'b0, 5'd0, 32'h0,       1'b1, 1'b0, 1'b0, C_NONE, 32'h00000004, 32'h22,       32'h22,       32'h0,        5'd6});
    vq.push_back('{1'b1, itype(6'h2B, 5'd2, 5'd6, 16'h0004), 1'b0, 5'd0, 32'h0,       1'b0, 1'b0, 1'b1, C_SW,   32'h00000004, 32'h22,       32'h22,       32'h0,        5'd6});
    vq.push_back('{1'b1, itype(6'h04, 5'd2, 5'd5, 16'hFFFF), 1'b0, 5'd0, 32'h0,       1'b0, 1'b0, 1'b1, C_BEQ,  32'hFFFFFFFF, 32'h22,       32'h22,       32'h55,       5'd5});
    vq.push_back('{1'b1, itype(6'h3F, 5'd0, 5'd0, 16'h8000), 1'b0, 5'd0, 32'h0,       1'b0, 1'b0, 1'b1, C_ILL,  32'hFFFF8000, 32'h0,        32'h0,        32'h0,        5'd0});
    vq.push_back('{1'b1, itype(6'h23, 5'd2, 5'd9, 16'h0000), 1'b0, 5'd0, 32'h0,       1'b0, 1'b0, 1'b1, C_LW,   32'h0,        32'h22,       32'h22,       32'h0,        5'd9});
    vq.push_back('{1'b1, rtype(5'd9, 5'd0, 5'd10),           1'b0, 5'd0, 32'h0,       1'b1, 1'b1, 1'b0, C_NONE, 32'h00005020, 32'h0,        32'h0,        32'h0,        5'd0});
    vq.push_back('{1'b1, itype(6'h08, 5'd0, 5'd11, 16'h0001),1'b0, 5'd0, 32'h0,       1'b0, 1'b0, 1'b1, C_ADDI, 32'h00000001, 32'h0,        32'h0,        32'h0,        5'd11});
    vq.push_back('{1'b1, itype(6'h23, 5'd2, 5'd0, 16'h0000), 1'b0, 5'd0, 32'h0,       1'b0, 1'b0, 1'b1, C_LW,   32'h0,        32'h22,       32'h22,       32'h0,        5'd0});
    vq.push_back('{1'b1, rtype(5'd0, 5'd0, 5'd1),            1'b0, 5'd0, 32'h0,       1'b0, 1'b0, 1'b1, C_R,    32'h00000820, 32'h0,        32'h0,        32'h0,        5'd0});
    vq.push_back('{1'b1, itype(6'h23, 5'd1, 5'd2, 16'h0000), 1'b0, 5'd0, 32'h0,       1'b0, 1'b0, 1'b1, C_LW,   32'h0,        32'h0,        32'h0,        32'h22,       5'd2});
    vq.push_back('{1'b0, rtype(5'd2, 5'd5, 5'd4),            1'b0, 5'd0, 32'h0,       1'b0, 1'b0, 1'b0, C_NONE, 32'h00002020, 32'h22,       32'h22,       32'h55,       5'd5});

    // Reset held low for two cycles.
    reset = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stall", {31'b0, stall}, 32'h0);
    chk("rst_valid", {31'b0, ex_valid}, 32'h0);
    chk("rst_ctrl", {22'b0, act_ctrl()}, 32'h0);
    chk("rst_imm", ex_imm, 32'h0);
    chk("rst_rs_data", ex_rs_data, 32'h0);

    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < vq.size(); i++) begin
      if (i != 0) @(negedge clk);
      drive(vq[i].iv, vq[i].ins, vq[i].wbe, vq[i].wbr, vq[i].wbd, vq[i].fl);
      #1;
      chk($sformatf("v%0d_stall", i), {31'b0, stall}, {31'b0, vq[i].stall});
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_valid", i), {31'b0, ex_valid}, {31'b0, vq[i].v});
      chk($sformatf("v%0d_ctrl", i), {22'b0, act_ctrl()}, {22'b0, vq[i].ctrl});
      chk($sformatf("v%0d_imm", i), ex_imm, vq[i].imm);
      chk($sformatf("v%0d_rs_data", i), ex_rs_data, vq[i].rs);
      chk($sformatf("v%0d_rs_data_nobypass", i), nb_rs_data, vq[i].rs_nb);
      chk($sformatf("v%0d_rt_data", i), ex_rt_data, vq[i].rt);
      chk($sformatf("v%0d_ex_rt", i), {27'b0, ex_rt}, {27'b0, vq[i].rti});
    end

    // Reset asserted while a load-use stall is pending.
    @(negedge clk);
    drive(1'b1, itype(6'h23, 5'd1, 5'd2, 16'h0000), 1'b0, 5'd0, 32'h0, 1'b0);
    @(negedge clk);
    drive(1'b1, rtype(5'd2, 5'd5, 5'd4), 1'b0, 5'd0, 32'h0, 1'b0);
    #1;
    chk("rs_stall_before", {31'b0, stall}, 32'h1);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("rs_stall_after", {31'b0, stall}, 32'h0);
    chk("rs_valid_after", {31'b0, ex_valid}, 32'h0);
    chk("rs_ctrl_after", {22'b0, act_ctrl()}, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rs_stall_released", {31'b0, stall}, 32'h0);
    @(posedge clk);
    #1;
    chk("rs_add_valid", {31'b0, ex_valid}, 32'h1);
    chk("rs_add_ctrl", {22'b0, act_ctrl()}, {22'b0, C_R});
    chk("rs_reg2_cleared", ex_rs_data, 32'h0);
    chk("rs_reg5_cleared", ex_rt_data, 32'h0);
    @(negedge clk);
    drive(1'b1, rtype(5'd3, 5'd0, 5'd4), 1'b0, 5'd0, 32'h0, 1'b0);
    @(posedge clk);
    #1;
    chk("rs_reg3_cleared", ex_rs_data, 32'h0);
    chk("rs_reg3_cleared_nobypass", nb_rs_data, 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
